video_dnn_argmax_count: RTL and testbench
=========================================

# video_dnn_argmax_count

Parametrised successor to the single-bit class max-counter in the MNIST video path. It sits after the CNN core and receives one AXI4-Stream beat per pixel carrying NUM_CLASS × CHANNEL_WIDTH binary votes. For each pixel it scores every class by popcount over its CHANNEL_WIDTH bits, selects the winning class, and applies a per-frame score threshold with a reject code. Output is a fixed-latency AXI4-Stream pipeline with full backpressure, and the input votes, tuser and tlast are passed through aligned with the result.

## Interface
Parameters:
- NUM_CLASS, 10, number of classes.
- CHANNEL_WIDTH, 4, vote bits per class; class c occupies tdata[c*CHANNEL_WIDTH +: CHANNEL_WIDTH].
- TUSER_WIDTH, 1, user sideband width; bit 0 is frame start.
- TNUMBER_WIDTH, 4, class-index width; must hold NUM_CLASS (the reject code).
- TCOUNT_WIDTH, 4, score width; must hold CHANNEL_WIDTH.
- TDATA_WIDTH, NUM_CLASS*CHANNEL_WIDTH, vote vector width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- param_th  in  TCOUNT_WIDTH  minimum winning score for acceptance.
- param_reject_en  in  1  1 = enable threshold rejection.
- s_axi4s_tuser  in  TUSER_WIDTH  sideband.
- s_axi4s_tlast  in  1  end of line.
- s_axi4s_tdata  in  TDATA_WIDTH  votes.
- s_axi4s_tvalid  in  1  input valid.
- s_axi4s_tready  out  1  input ready.
- m_axi4s_tuser  out  TUSER_WIDTH  delayed tuser.
- m_axi4s_tlast  out  1  delayed tlast.
- m_axi4s_tnumber  out  TNUMBER_WIDTH  winning class, or NUM_CLASS if rejected.
- m_axi4s_tcount  out  TCOUNT_WIDTH  winning score.
- m_axi4s_tdata  out  TDATA_WIDTH  delayed votes.
- m_axi4s_tvalid  out  1  output valid.
- m_axi4s_tready  in  1  output ready.

## Operation
- One clock (aclk). aresetn is synchronous and active-low: sampled low at a rising edge, it resets the block on that edge.
- Pipeline stages:
  - S1: register the per-class popcount, which ranges 0..CHANNEL_WIDTH.
  - S2: linear compare across classes; register the winner index and score.
  - S3: apply the threshold; register the outputs.
- Argmax tie rule: on equal scores the lowest class index wins. All scores 0 gives tnumber=0, tcount=0.
- Threshold: if the S3 shadow reject_en=1 and score < shadow th, then tnumber=NUM_CLASS. tcount still carries the true score.
- Parameter shadowing: param_th and param_reject_en are copied into shadow registers when an input beat with tuser[0]=1 is accepted. The shadow values travel with the beat, so all pixels of one frame use one parameter set. Parameter changes mid-frame have no effect until the next frame start.
- tuser, tlast and tdata are delayed unchanged alongside the result.
- Reset values:
  - m_axi4s_tvalid=0.
  - tnumber, tcount, tuser, tlast, tdata = 0.
  - Shadow th = 0 and shadow reject_en = 0, i.e. no rejection until the first frame start.
  - All internal stage-valid flags = 0.

## Timing
- Global stall enable: cke = !m_axi4s_tvalid || m_axi4s_tready. All three stages advance only when cke=1.
- s_axi4s_tready = cke, combinational from m_axi4s_tready. This path is documented and is the only combinational path.
- A beat is accepted when s_axi4s_tvalid && s_axi4s_tready.
- Latency is exactly 3 cycles from acceptance to m_axi4s_tvalid with m_axi4s_tready held high.
- Throughput is 1 beat per cycle.
- Bubbles propagate as stage-valid=0 and do not collapse while cke=1.
- Handshake rules:
  - m_axi4s_tvalid never deasserts, and the outputs never change, while m_axi4s_tvalid=1 && m_axi4s_tready=0.
  - No beat is dropped or duplicated under any tready pattern.
- Simultaneous frame start and stall: shadow parameters update only on an actual acceptance.
- Reset mid-stream: all in-flight beats are discarded and m_axi4s_tvalid=0 on the next cycle. The first beat after reset appears 3 cycles after its acceptance.

## Test plan
- Single pixel, NUM_CLASS=10, CHANNEL_WIDTH=4, class 7 votes=4'b1011, all others 4'b0001 -> after 3 cycles tnumber=7, tcount=3, tdata echoed.
- Tie: class 2 and class 5 both 4'b1111, others 0 -> tnumber=2, tcount=4. All classes zero -> tnumber=0, tcount=0.
- Threshold: frame start with param_th=3, reject_en=1; pixel winning score 2 -> tnumber=10, tcount=2. Score 3 -> accepted.
- Shadowing: change param_th from 3 to 1 mid-frame -> remaining pixels of that frame still use 3. The next tuser[0]=1 beat and onward use 1.
- Backpressure: 64-beat stream with random tvalid and random m_axi4s_tready (~50%) -> output sequence identical to the golden model. Outputs are stable while stalled, and nothing is lost or duplicated.
- Reset: assert aresetn=0 for 1 cycle with 3 beats in flight -> m_axi4s_tvalid=0 next cycle and those beats never appear. The shadow threshold returns to 0, so there is no rejection until the next frame start.

Source files
------------

// File: rtl/video_dnn_argmax_count.sv
// Per-pixel class argmax over popcounted binary votes, with a per-frame score threshold.
// Three-stage AXI4-Stream pipeline; every stage advances under a single global stall enable.
module video_dnn_argmax_count #(
  parameter int NUM_CLASS     = 10,
  parameter int CHANNEL_WIDTH = 4,
  parameter int TUSER_WIDTH   = 1,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = 4,
  parameter int TDATA_WIDTH   = NUM_CLASS * CHANNEL_WIDTH
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [TCOUNT_WIDTH-1:0]  param_th,
  input  logic                     param_reject_en,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
  output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
  output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready
);

  logic cke;
  logic accept;
  logic frameStart;
  logic [TCOUNT_WIDTH-1:0] thEff;
  logic                    rejEff;

  logic [TCOUNT_WIDTH-1:0] shadowTh_q;
  logic                    shadowRej_q;

  logic                                      s1Valid_q;
  logic [NUM_CLASS-1:0][TCOUNT_WIDTH-1:0]    s1Pop_d, s1Pop_q;
  logic [TUSER_WIDTH-1:0]                    s1User_q;
  logic                                      s1Last_q;
  logic [TDATA_WIDTH-1:0]                    s1Data_q;
  logic [TCOUNT_WIDTH-1:0]                   s1Th_q;
  logic                                      s1Rej_q;

  logic                     s2Valid_q;
  logic [TNUMBER_WIDTH-1:0] s2Idx_d, s2Idx_q;
  logic [TCOUNT_WIDTH-1:0]  s2Score_d, s2Score_q;
  logic [TUSER_WIDTH-1:0]   s2User_q;
  logic                     s2Last_q;
  logic [TDATA_WIDTH-1:0]   s2Data_q;
  logic [TCOUNT_WIDTH-1:0]  s2Th_q;
  logic                     s2Rej_q;

  logic                     outValid_q;
  logic [TNUMBER_WIDTH-1:0] outNumber_d, outNumber_q;
  logic [TCOUNT_WIDTH-1:0]  outCount_q;
  logic [TUSER_WIDTH-1:0]   outUser_q;
  logic                     outLast_q;
  logic [TDATA_WIDTH-1:0]   outData_q;

  assign cke            = !outValid_q || m_axi4s_tready;
  assign s_axi4s_tready = cke;
  assign accept         = s_axi4s_tvalid && cke;
  assign frameStart     = accept && s_axi4s_tuser[0];

  // A frame-start beat already uses the parameters it brings with it.
  assign thEff  = s_axi4s_tuser[0] ? param_th        : shadowTh_q;
  assign rejEff = s_axi4s_tuser[0] ? param_reject_en : shadowRej_q;

  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      s1Pop_d[c] = '0;
      for (int b = 0; b < CHANNEL_WIDTH; b++) begin
        s1Pop_d[c] = s1Pop_d[c] + TCOUNT_WIDTH'(s_axi4s_tdata[c*CHANNEL_WIDTH + b]);
      end
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    s2Idx_d   = '0;
    s2Score_d = s1Pop_q[0];
    for (int c = 1; c < NUM_CLASS; c++) begin
      if (s1Pop_q[c] > s2Score_d) begin
        s2Idx_d   = TNUMBER_WIDTH'(c);
        s2Score_d = s1Pop_q[c];
      end
    end
  end

  always_comb begin
    outNumber_d = s2Idx_q;
    if (s2Rej_q && (s2Score_q < s2Th_q)) begin
      outNumber_d = TNUMBER_WIDTH'(NUM_CLASS);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      shadowTh_q  <= '0;
      shadowRej_q <= 1'b0;
      s1Valid_q   <= 1'b0;
      s1Pop_q     <= '0;
      s1User_q    <= '0;
      s1Last_q    <= 1'b0;
      s1Data_q    <= '0;
      s1Th_q      <= '0;
      s1Rej_q     <= 1'b0;
      s2Valid_q   <= 1'b0;
      s2Idx_q     <= '0;
      s2Score_q   <= '0;
      s2User_q    <= '0;
      s2Last_q    <= 1'b0;
      s2Data_q    <= '0;
      s2Th_q      <= '0;
      s2Rej_q     <= 1'b0;
      outValid_q  <= 1'b0;
      outNumber_q <= '0;
      outCount_q  <= '0;
      outUser_q   <= '0;
      outLast_q   <= 1'b0;
      outData_q   <= '0;
    end else begin
      if (frameStart) begin
        shadowTh_q  <= param_th;
        shadowRej_q <= param_reject_en;
      end
      if (cke) begin
        s1Valid_q   <= s_axi4s_tvalid;
        s1Pop_q     <= s1Pop_d;
        s1User_q    <= s_axi4s_tuser;
        s1Last_q    <= s_axi4s_tlast;
        s1Data_q    <= s_axi4s_tdata;
        s1Th_q      <= thEff;
        s1Rej_q     <= rejEff;
        s2Valid_q   <= s1Valid_q;
        s2Idx_q     <= s2Idx_d;
        s2Score_q   <= s2Score_d;
        s2User_q    <= s1User_q;
        s2Last_q    <= s1Last_q;
        s2Data_q    <= s1Data_q;
        s2Th_q      <= s1Th_q;
        s2Rej_q     <= s1Rej_q;
        outValid_q  <= s2Valid_q;
        outNumber_q <= outNumber_d;
        outCount_q  <= s2Score_q;
        outUser_q   <= s2User_q;
        outLast_q   <= s2Last_q;
        outData_q   <= s2Data_q;
      end
    end
  end

  assign m_axi4s_tvalid  = outValid_q;
  assign m_axi4s_tnumber = outNumber_q;
  assign m_axi4s_tcount  = outCount_q;
  assign m_axi4s_tuser   = outUser_q;
  assign m_axi4s_tlast   = outLast_q;
  assign m_axi4s_tdata   = outData_q;

endmodule

// File: tb/tb_video_dnn_argmax_count.sv
// Self-checking bench for video_dnn_argmax_count: directed vector table, reset
// flush sequence and a randomised backpressure stream against a reference model.
module tb_video_dnn_argmax_count;

   localparam int NC  = 10;
   localparam int CW  = 4;
   localparam int TDW = NC * CW;

   logic           aclk;
   logic           aresetn;
   logic [3:0]     param_th;
   logic           param_reject_en;
   logic [0:0]     s_axi4s_tuser;
   logic           s_axi4s_tlast;
   logic [TDW-1:0] s_axi4s_tdata;
   logic           s_axi4s_tvalid;
   logic           s_axi4s_tready;
   logic [0:0]     m_axi4s_tuser;
   logic           m_axi4s_tlast;
   logic [3:0]     m_axi4s_tnumber;
   logic [3:0]     m_axi4s_tcount;
   logic [TDW-1:0] m_axi4s_tdata;
   logic           m_axi4s_tvalid;
   logic           m_axi4s_tready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic           tuser;
      logic           tlast;
      logic [TDW-1:0] tdata;
      logic [3:0]     th;
      logic           rej;
      logic [3:0]     expNum;
      logic [3:0]     expCnt;
   } vec_t;

   typedef struct {
      logic [3:0]     num;
      logic [3:0]     cnt;
      logic [TDW-1:0] data;
      logic           user;
      logic           last;
   } exp_t;

   vec_t vecs[11];
   exp_t expQ[$];

   video_dnn_argmax_count dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .param_th        (param_th),
      .param_reject_en (param_reject_en),
      .s_axi4s_tuser   (s_axi4s_tuser),
      .s_axi4s_tlast   (s_axi4s_tlast),
      .s_axi4s_tdata   (s_axi4s_tdata),
      .s_axi4s_tvalid  (s_axi4s_tvalid),
      .s_axi4s_tready  (s_axi4s_tready),
      .m_axi4s_tuser   (m_axi4s_tuser),
      .m_axi4s_tlast   (m_axi4s_tlast),
      .m_axi4s_tnumber (m_axi4s_tnumber),
      .m_axi4s_tcount  (m_axi4s_tcount),
      .m_axi4s_tdata   (m_axi4s_tdata),
      .m_axi4s_tvalid  (m_axi4s_tvalid),
      .m_axi4s_tready  (m_axi4s_tready)
   );

   // Free-running 100 MHz clock
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Builds a vote vector with every class set to the same pattern
   function automatic logic [TDW-1:0] fillAll(input logic [3:0] pattern);
      logic [TDW-1:0] d;
      for (int c = 0; c < NC; c++) d[c*CW +: CW] = pattern;
      return d;
   endfunction

   function automatic vec_t mkVec(input logic u, input logic l, input logic [TDW-1:0] d,
                                  input logic [3:0] th, input logic rej,
                                  input logic [3:0] en, input logic [3:0] ec);
      vec_t v;
      v.tuser = u; v.tlast = l; v.tdata = d; v.th = th; v.rej = rej;
      v.expNum = en; v.expCnt = ec;
      return v;
   endfunction

   // Reference argmax with lowest-index tie break and threshold rejection
   function automatic exp_t model(input logic [TDW-1:0] d, input logic u, input logic l,
                                  input logic [3:0] th, input logic rej);
      exp_t e;
      int best = 0;
      int bestIdx = 0;
      int s;
      for (int c = 0; c < NC; c++) begin
         s = $countones(d[c*CW +: CW]);
         if (s > best) begin
            best = s;
            bestIdx = c;
         end
      end
      e.num  = (rej && (best < int'(th))) ? 4'd10 : 4'(bestIdx);
      e.cnt  = 4'(best);
      e.data = d;
      e.user = u;
      e.last = l;
      return e;
   endfunction

   // Sends one beat into an idle pipeline and checks latency and result
   task automatic applyStimulus(input string name, input vec_t v);
      int lat;
      @(negedge aclk);
      m_axi4s_tready  = 1'b1;
      s_axi4s_tuser   = v.tuser;
      s_axi4s_tlast   = v.tlast;
      s_axi4s_tdata   = v.tdata;
      param_th        = v.th;
      param_reject_en = v.rej;
      s_axi4s_tvalid  = 1'b1;
      @(posedge aclk);
      #1;
      s_axi4s_tvalid = 1'b0;
      lat = 1;
      while (!m_axi4s_tvalid && lat < 8) begin
         @(posedge aclk);
         #1;
         lat++;
      end
      checkOutput({name, ".latency"}, 64'(lat), 64'd3);
      checkOutput({name, ".tnumber"}, 64'(m_axi4s_tnumber), 64'(v.expNum));
      checkOutput({name, ".tcount"},  64'(m_axi4s_tcount),  64'(v.expCnt));
      checkOutput({name, ".tdata"},   64'(m_axi4s_tdata),   64'(v.tdata));
      checkOutput({name, ".tuser"},   64'(m_axi4s_tuser),   64'(v.tuser));
      checkOutput({name, ".tlast"},   64'(m_axi4s_tlast),   64'(v.tlast));
   endtask

   initial begin
      logic [TDW-1:0] d;
      logic           holdValid;
      logic           accepted;
      logic [3:0]     modelTh;
      logic           modelRej;
      logic [3:0]     savedNum;
      logic [3:0]     savedCnt;
      logic [TDW-1:0] savedData;
      logic           savedUser;
      logic           savedLast;
      logic           ghost;
      int             sent;
      int             got;
      exp_t           e;

      // Directed vector table, expected values worked out by hand
      d = fillAll(4'b0001); d[7*CW +: CW] = 4'b1011;
      vecs[0] = mkVec(1'b1, 1'b0, d, 4'd0, 1'b0, 4'd7, 4'd3);
      d = '0; d[2*CW +: CW] = 4'b1111; d[5*CW +: CW] = 4'b1111;
      vecs[1] = mkVec(1'b0, 1'b0, d, 4'd0, 1'b0, 4'd2, 4'd4);
      vecs[2] = mkVec(1'b0, 1'b0, '0, 4'd0, 1'b0, 4'd0, 4'd0);
      d = '0; d[4*CW +: CW] = 4'b0011;
      vecs[3] = mkVec(1'b1, 1'b0, d, 4'd3, 1'b1, 4'd10, 4'd2);
      d = '0; d[9*CW +: CW] = 4'b0111;
      vecs[4] = mkVec(1'b0, 1'b0, d, 4'd1, 1'b1, 4'd9, 4'd3);
      d = '0; d[1*CW +: CW] = 4'b0101;
      vecs[5] = mkVec(1'b0, 1'b0, d, 4'd1, 1'b1, 4'd10, 4'd2);
      d = '0; d[0 +: CW] = 4'b0001;
      vecs[6] = mkVec(1'b1, 1'b0, d, 4'd1, 1'b1, 4'd0, 4'd1);
      vecs[7] = mkVec(1'b0, 1'b0, '0, 4'd3, 1'b0, 4'd10, 4'd0);
      vecs[8] = mkVec(1'b1, 1'b1, '0, 4'd4, 1'b0, 4'd0, 4'd0);
      d = '0; d[8*CW +: CW] = 4'b1111; d[3*CW +: CW] = 4'b0111;
      vecs[9] = mkVec(1'b1, 1'b1, d, 4'd4, 1'b1, 4'd8, 4'd4);
      d = '0; d[3*CW +: CW] = 4'b1110; d[6*CW +: CW] = 4'b1110;
      vecs[10] = mkVec(1'b0, 1'b0, d, 4'd0, 1'b0, 4'd10, 4'd3);

      aresetn         = 1'b0;
      param_th        = '0;
      param_reject_en = 1'b0;
      s_axi4s_tuser   = '0;
      s_axi4s_tlast   = 1'b0;
      s_axi4s_tdata   = '0;
      s_axi4s_tvalid  = 1'b0;
      m_axi4s_tready  = 1'b1;

      // Reset state
      repeat (3) @(posedge aclk);
      #1;
      checkOutput("reset.tvalid",  64'(m_axi4s_tvalid),  64'd0);
      checkOutput("reset.tnumber", 64'(m_axi4s_tnumber), 64'd0);
      checkOutput("reset.tcount",  64'(m_axi4s_tcount),  64'd0);
      checkOutput("reset.tdata",   64'(m_axi4s_tdata),   64'd0);
      checkOutput("reset.tuser",   64'(m_axi4s_tuser),   64'd0);
      checkOutput("reset.tlast",   64'(m_axi4s_tlast),   64'd0);
      checkOutput("reset.tready",  64'(s_axi4s_tready),  64'd1);
      @(negedge aclk);
      aresetn = 1'b1;

      for (int i = 0; i < 11; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i]);
      end

      // Three beats in flight behind a stalled output, then a one-cycle reset
      repeat (2) @(negedge aclk);
      m_axi4s_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge aclk);
         d = '0; d[i*CW +: CW] = 4'b1111;
         s_axi4s_tdata   = d;
         s_axi4s_tuser   = (i == 0) ? 1'b1 : 1'b0;
         s_axi4s_tlast   = 1'b0;
         param_th        = 4'd4;
         param_reject_en = 1'b1;
         s_axi4s_tvalid  = 1'b1;
      end
      @(negedge aclk);
      s_axi4s_tvalid = 1'b0;
      checkOutput("flush.inflight", 64'(m_axi4s_tvalid), 64'd1);
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      checkOutput("flush.tvalid", 64'(m_axi4s_tvalid), 64'd0);
      aresetn        = 1'b1;
      m_axi4s_tready = 1'b1;
      ghost = 1'b0;
      repeat (6) begin
         @(posedge aclk);
         #1;
         if (m_axi4s_tvalid) ghost = 1'b1;
      end
      checkOutput("flush.noghost", 64'(ghost), 64'd0);
      d = '0; d[5*CW +: CW] = 4'b0001;
      applyStimulus("postreset", mkVec(1'b0, 1'b0, d, 4'd4, 1'b1, 4'd5, 4'd1));

      // Randomised valid/ready stream against the reference model
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      aresetn   = 1'b1;
      modelTh   = '0;
      modelRej  = 1'b0;
      sent      = 0;
      got       = 0;
      holdValid = 1'b0;
      savedNum  = '0; savedCnt = '0; savedData = '0; savedUser = 1'b0; savedLast = 1'b0;
      s_axi4s_tvalid = 1'b0;
      for (int cyc = 0; cyc < 3000 && got < 64; cyc++) begin
         @(negedge aclk);
         if (holdValid) begin
            checkOutput("stall.tvalid",  64'(m_axi4s_tvalid),  64'd1);
            checkOutput("stall.tnumber", 64'(m_axi4s_tnumber), 64'(savedNum));
            checkOutput("stall.tcount",  64'(m_axi4s_tcount),  64'(savedCnt));
            checkOutput("stall.tdata",   64'(m_axi4s_tdata),   64'(savedData));
            checkOutput("stall.tuser",   64'(m_axi4s_tuser),   64'(savedUser));
            checkOutput("stall.tlast",   64'(m_axi4s_tlast),   64'(savedLast));
         end
         holdValid = m_axi4s_tvalid && !m_axi4s_tready;
         savedNum  = m_axi4s_tnumber;
         savedCnt  = m_axi4s_tcount;
         savedData = m_axi4s_tdata;
         savedUser = m_axi4s_tuser[0];
         savedLast = m_axi4s_tlast;
         if (m_axi4s_tvalid && m_axi4s_tready) begin
            if (expQ.size() == 0) begin
               checkOutput("stream.extra", 64'd1, 64'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput($sformatf("stream%0d.tnumber", got), 64'(m_axi4s_tnumber), 64'(e.num));
               checkOutput($sformatf("stream%0d.tcount", got),  64'(m_axi4s_tcount),  64'(e.cnt));
               checkOutput($sformatf("stream%0d.tdata", got),   64'(m_axi4s_tdata),   64'(e.data));
               checkOutput($sformatf("stream%0d.tuser", got),   64'(m_axi4s_tuser),   64'(e.user));
               checkOutput($sformatf("stream%0d.tlast", got),   64'(m_axi4s_tlast),   64'(e.last));
               got++;
            end
         end
         accepted = s_axi4s_tvalid && s_axi4s_tready;
         if (accepted) begin
            if (s_axi4s_tuser[0]) begin
               modelTh  = param_th;
               modelRej = param_reject_en;
            end
            expQ.push_back(model(s_axi4s_tdata, s_axi4s_tuser[0], s_axi4s_tlast, modelTh, modelRej));
            sent++;
         end
         @(posedge aclk);
         #1;
         if (!s_axi4s_tvalid || accepted) begin
            if (sent < 64 && $urandom_range(1, 0) == 1) begin
               for (int c = 0; c < NC; c++) s_axi4s_tdata[c*CW +: CW] = 4'($urandom_range(15, 0));
               s_axi4s_tuser  = (sent == 0 || $urandom_range(7, 0) == 0) ? 1'b1 : 1'b0;
               s_axi4s_tlast  = ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0;
               s_axi4s_tvalid = 1'b1;
            end else begin
               s_axi4s_tvalid = 1'b0;
            end
         end
         param_th        = 4'($urandom_range(4, 0));
         param_reject_en = 1'($urandom_range(1, 0));
         m_axi4s_tready  = ($urandom_range(1, 0) == 1);
      end
      checkOutput("stream.count", 64'(got), 64'd64);
      s_axi4s_tvalid = 1'b0;
      m_axi4s_tready = 1'b1;
      ghost = 1'b0;
      repeat (8) begin
         @(posedge aclk);
         #1;
         if (m_axi4s_tvalid) ghost = 1'b1;
      end
      checkOutput("stream.noduplicate", 64'(ghost), 64'd0);
      checkOutput("stream.drained", 64'(expQ.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
